// File: rtl/pcim_stream_writer.sv
// AXI4 write initiator that drains a 512-bit result stream into host memory.
// Bursts never cross a 4 KB page, and only one burst is outstanding at a time.
module pcim_stream_writer #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 16,
  parameter int AXI_ID    = 0,
  parameter int MAX_BEATS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [31:0]         total_beats,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         beats_written,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rem;
  logic [6:0]        r_len;
  logic [6:0]        r_beat;
  logic              r_error;
  logic [31:0]       r_beatsWritten;

  logic [ADDR_W-1:0] w_baseAligned;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [31:0]       w_nextRem;
  logic              w_lastBeat;
  logic              w_wHandshake;
  logic              w_unused;

  // Burst length is the smallest of remaining beats, MAX_BEATS and beats left in the 4 KB page.
  function automatic logic [6:0] calcLen(input logic [ADDR_W-1:0] addr, input logic [31:0] rem);
    logic [6:0] room;
    logic [6:0] len;
    room = 7'd64 - {1'b0, addr[11:6]};
    len  = (room < 7'(MAX_BEATS)) ? room : 7'(MAX_BEATS);
    if (rem < {25'd0, len}) len = rem[6:0];
    return len;
  endfunction

  assign w_baseAligned = {base_addr[ADDR_W-1:6], 6'd0};
  assign w_nextAddr    = r_addr + ADDR_W'({r_len, 6'd0});
  assign w_nextRem     = r_rem - {25'd0, r_len};
  assign w_lastBeat    = (r_beat == r_len - 7'd1);
  assign w_wHandshake  = wvalid & wready;
  assign w_unused      = ^{bid, base_addr[5:0]};

  assign busy          = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_RESP);
  assign done          = (r_state == S_FIN);
  assign error         = r_error;
  assign beats_written = r_beatsWritten;

  assign awid    = ID_W'(AXI_ID);
  assign awsize  = 3'b110;
  assign awaddr  = r_addr;
  assign awlen   = {1'b0, 7'(r_len - 7'd1)};
  assign awvalid = (r_state == S_ADDR);

  // The W channel is a zero-latency pass-through of the stream while in DATA.
  assign wdata    = s_tdata;
  assign wstrb    = '1;
  assign wvalid   = (r_state == S_DATA) & s_tvalid;
  assign s_tready = (r_state == S_DATA) & wready;
  assign wlast    = (r_state == S_DATA) & w_lastBeat;
  assign bready   = (r_state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_rem          <= '0;
      r_len          <= '0;
      r_beat         <= '0;
      r_error        <= 1'b0;
      r_beatsWritten <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error        <= 1'b0;
            r_beatsWritten <= '0;
            r_beat         <= '0;
            if (total_beats != 32'd0) begin
              r_addr  <= w_baseAligned;
              r_rem   <= total_beats;
              r_len   <= calcLen(w_baseAligned, total_beats);
              r_state <= S_ADDR;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_ADDR: begin
          if (awready) begin
            r_beat  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wHandshake) begin
            r_beat <= r_beat + 7'd1;
            if (w_lastBeat) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // An error response abandons the rest of the transfer without draining the stream.
          if (bvalid) begin
            if (bresp == 2'b00) begin
              r_rem          <= w_nextRem;
              r_addr         <= w_nextAddr;
              r_beatsWritten <= r_beatsWritten + {25'd0, r_len};
              if (w_nextRem == 32'd0) begin
                r_state <= S_FIN;
              end else begin
                r_len   <= calcLen(w_nextAddr, w_nextRem);
                r_state <= S_ADDR;
              end
            end else begin
              r_error <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcim_stream_writer.sv
// Bench for pcim_stream_writer: a table of directed transfers plus randomized ones,
// checked against a burst-splitting reference model and a stalling AXI slave.
module tb_pcim_stream_writer;

  localparam int DATA_W    = 512;
  localparam int ADDR_W    = 64;
  localparam int ID_W      = 16;
  localparam int MAX_BEATS = 64;

  logic                clk;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [31:0]         total_beats;
  logic                busy, done, error;
  logic [31:0]         beats_written;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid, s_tready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;

  pcim_stream_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(0), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_beats(total_beats),
    .busy(busy), .done(done), .error(error), .beats_written(beats_written),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base;
    int          total;
    int          failIdx;
    int          stall;
    int          expAw;
    int          expBeats;
    logic        expErr;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Shared setup, written only by the main process.
  logic [DATA_W-1:0] srcWords[512];
  int                srcCount;
  logic [63:0]       modelAddr[64];
  int                modelLen[64];
  int                modelN;
  int                failIdx;
  int                stallPct;
  int                epoch;

  // Slave/monitor state, written only by the monitor process.
  int          srcIdx, awCnt, wBursts, beatInBurst, pendingB, bIdx, doneCnt, protoErr, dataErr, myEpoch;
  logic [63:0] gotAddr[64];
  int          gotLen[64];
  logic [63:0] prevAddr;
  logic [7:0]  prevLen;
  logic        prevPending, hsB;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference: walk the transfer page by page, cutting bursts at 4 KB and MAX_BEATS.
  task automatic buildModel(input logic [63:0] base, input int total);
    logic [63:0] a;
    longint rem, room, len;
    a = base - (base % 64);
    rem = total;
    modelN = 0;
    while (rem > 0) begin
      room = longint'((64'd4096 - (a % 64'd4096)) / 64);
      len = rem;
      if (len > MAX_BEATS) len = MAX_BEATS;
      if (len > room) len = room;
      modelAddr[modelN] = a;
      modelLen[modelN] = int'(len);
      modelN++;
      a = a + 64'(len * 64);
      rem = rem - len;
    end
  endtask

  // AXI slave and stream source with random stalls; observes handshakes just before each rising edge.
  initial begin
    logic expLast;
    s_tvalid = 1'b0; s_tdata = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; bid = '0;
    myEpoch = 0; hsB = 1'b0; prevPending = 1'b0;
    srcIdx = 0; awCnt = 0; wBursts = 0; beatInBurst = 0; pendingB = 0; bIdx = 0;
    doneCnt = 0; protoErr = 0; dataErr = 0; prevAddr = '0; prevLen = '0;
    forever begin
      @(negedge clk);
      if (epoch != myEpoch) begin
        myEpoch = epoch;
        srcIdx = 0; awCnt = 0; wBursts = 0; beatInBurst = 0; pendingB = 0; bIdx = 0;
        doneCnt = 0; protoErr = 0; dataErr = 0; prevPending = 1'b0; hsB = 1'b0;
        bvalid = 1'b0;
      end
      s_tvalid = (srcIdx < srcCount) && ($urandom_range(99) >= stallPct);
      s_tdata  = (srcIdx < srcCount) ? srcWords[srcIdx] : '0;
      awready  = ($urandom_range(99) >= stallPct);
      wready   = ($urandom_range(99) >= stallPct);
      if (!(bvalid && !hsB)) begin
        bvalid = 1'b0;
        if (pendingB > 0 && $urandom_range(99) >= stallPct) begin
          bvalid = 1'b1;
          bresp  = (bIdx == failIdx) ? 2'b10 : 2'b00;
        end
      end
      #1;
      if (prevPending && (!awvalid || awaddr != prevAddr || awlen != prevLen)) protoErr++;
      prevPending = awvalid && !awready;
      prevAddr = awaddr;
      prevLen = awlen;
      if ((wvalid && wready) != (s_tvalid && s_tready)) protoErr++;
      if (wvalid && wready) begin
        if (awCnt <= wBursts) protoErr++;
        if (srcIdx >= srcCount || wdata !== srcWords[srcIdx]) dataErr++;
        srcIdx++;
        expLast = (wBursts < modelN) && (beatInBurst == modelLen[wBursts] - 1);
        if (wlast !== expLast) protoErr++;
        if (wlast) begin
          wBursts++; beatInBurst = 0; pendingB++;
        end else begin
          beatInBurst++;
        end
      end
      if (awvalid && awready) begin
        if (awCnt < 64) begin
          gotAddr[awCnt] = awaddr;
          gotLen[awCnt] = int'(awlen) + 1;
        end
        awCnt++;
      end
      hsB = bvalid && bready;
      if (hsB) begin
        pendingB--; bIdx++;
      end
      if (done) begin
        doneCnt++;
        if (busy) protoErr++;
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input string tag);
    int expWords;
    int cyc;
    @(posedge clk); #2;
    buildModel(v.base, v.total);
    srcCount = v.total;
    for (int i = 0; i < v.total; i++) srcWords[i] = randWord();
    failIdx = v.failIdx;
    stallPct = v.stall;
    epoch++;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; total_beats = v.total;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy_after_start"}, busy, v.total > 0);
    for (cyc = 0; cyc < 5000 && doneCnt == 0; cyc++) @(negedge clk);
    checkOutput({tag, " done_in_time"}, doneCnt > 0, 1);
    repeat (3) @(negedge clk);
    expWords = 0;
    for (int i = 0; i < v.expAw && i < modelN; i++) expWords += modelLen[i];
    checkOutput({tag, " done_pulses"}, doneCnt, 1);
    checkOutput({tag, " busy_idle"}, busy, 0);
    checkOutput({tag, " error"}, error, v.expErr);
    checkOutput({tag, " beats_written"}, beats_written, v.expBeats);
    checkOutput({tag, " aw_count"}, awCnt, v.expAw);
    for (int i = 0; i < v.expAw && i < awCnt && i < 64; i++) begin
      checkOutput({tag, $sformatf(" aw%0d_addr", i)}, gotAddr[i], modelAddr[i]);
      checkOutput({tag, $sformatf(" aw%0d_len", i)}, gotLen[i], modelLen[i]);
    end
    checkOutput({tag, " words_consumed"}, srcIdx, expWords);
    checkOutput({tag, " protocol_errors"}, protoErr, 0);
    checkOutput({tag, " data_errors"}, dataErr, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t rv;
    int cyc;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0;
    epoch = 0; failIdx = -1; stallPct = 0; srcCount = 0; modelN = 0;

    vecs[0] = '{64'h1000, 4,   -1, 0,  1, 4,   1'b0};
    vecs[1] = '{64'h0F80, 10,  -1, 0,  2, 10,  1'b0};
    vecs[2] = '{64'h0000, 130, -1, 0,  3, 130, 1'b0};
    vecs[3] = '{64'h1000, 100, -1, 50, 2, 100, 1'b0};
    vecs[4] = '{64'h2FC0, 5,    0, 0,  1, 0,   1'b1};
    vecs[5] = '{64'h1000, 3,   -1, 30, 1, 3,   1'b0};
    vecs[6] = '{64'h103F, 2,   -1, 0,  1, 2,   1'b0};
    vecs[7] = '{64'h0FC0, 2,    1, 20, 2, 1,   1'b1};

    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset error", error, 0);
    checkOutput("reset awvalid", awvalid, 0);
    checkOutput("reset wvalid", wvalid, 0);
    checkOutput("reset bready", bready, 0);
    checkOutput("reset s_tready", s_tready, 0);
    checkOutput("reset beats_written", beats_written, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      rv.base = {32'h0, $urandom};
      rv.total = $urandom_range(200, 1);
      rv.stall = 50;
      buildModel(rv.base, rv.total);
      rv.failIdx = ($urandom_range(2) == 0) ? $urandom_range(modelN - 1) : -1;
      rv.expErr = (rv.failIdx >= 0);
      rv.expAw = rv.expErr ? rv.failIdx + 1 : modelN;
      rv.expBeats = 0;
      for (int k = 0; k < rv.expAw - (rv.expErr ? 1 : 0); k++) rv.expBeats += modelLen[k];
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a data burst, then a zero-length start.
    @(posedge clk); #2;
    buildModel(64'h4000, 8);
    srcCount = 8;
    for (int i = 0; i < 8; i++) srcWords[i] = randWord();
    failIdx = -1; stallPct = 0; epoch++;
    @(negedge clk);
    start = 1'b1; base_addr = 64'h4000; total_beats = 8;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 200 && srcIdx < 2; cyc++) @(negedge clk);
    checkOutput("midburst reached_data", srcIdx >= 2, 1);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst wvalid", wvalid, 0);
    checkOutput("midrst wlast", wlast, 0);
    checkOutput("midrst s_tready", s_tready, 0);
    checkOutput("midrst awvalid", awvalid, 0);
    checkOutput("midrst bready", bready, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst beats_written", beats_written, 0);
    @(negedge clk);
    rst = 1'b0;
    srcCount = 0;
    modelN = 0;
    epoch++;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; base_addr = 64'h8000; total_beats = 0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("zero done_pulse", done, 1);
    checkOutput("zero busy", busy, 0);
    checkOutput("zero awvalid", awvalid, 0);
    @(negedge clk); #1;
    checkOutput("zero done_cleared", done, 0);
    repeat (3) @(negedge clk);
    checkOutput("zero aw_count", awCnt, 0);
    checkOutput("zero words_consumed", srcIdx, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
